font_rom_arbiter: RTL and testbench



---
 rtl/font_rom_arbiter_pkg.sv | 10 +
 rtl/font_rom_arbiter_rr_pick.sv | 28 ++
 rtl/font_rom_arbiter.sv | 78 +++++++
 tb/tb_font_rom_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/font_rom_arbiter_pkg.sv
// font_rom_arbiter_pkg: shared font ROM geometry and index-width helper
package font_rom_arbiter_pkg;
  localparam int FONT_AW = 10;
  localparam int FONT_DW = 32;
  localparam int FONT_ROM_LAT = 1;
  localparam int FONT_N_REQ = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/font_rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible index at or after ptr
module rr_pick
  import font_rom_arbiter_pkg::*;
#(
  parameter int N = FONT_N_REQ,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);
  logic [N-1:0] w_rot;
  logic [IW:0]  w_off, w_sum;
  // rotate so bit 0 is the requester at ptr; ptr < N keeps the doubled vector sufficient
  assign w_rot = N'({i_elig, i_elig} >> i_ptr);
  always_comb begin
    o_found = 1'b0;
    w_off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (w_rot[i]) begin
        o_found = 1'b1;
        w_off = (IW + 1)'(i);
      end
  end
  assign w_sum = {1'b0, i_ptr} + w_off;
  assign o_idx = (w_sum >= (IW + 1)'(N)) ? IW'(w_sum - (IW + 1)'(N)) : IW'(w_sum);
endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: round-robin time-sharing of one synchronous font ROM among N_REQ readers
module font_rom_arbiter
  import font_rom_arbiter_pkg::*;
#(
  parameter int N_REQ = FONT_N_REQ,
  parameter int AW = FONT_AW,
  parameter int DW = FONT_DW,
  parameter int ROM_LAT = FONT_ROM_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [AW-1:0]       rom_address,
  input  logic [DW-1:0]       rom_data,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data
);
  localparam int IW = idx_w(N_REQ);
  logic [N_REQ-1:0]   r_pending, r_gnt, r_rsp_valid;
  logic [IW-1:0]      r_ptr, r_gnt_id;
  logic [AW-1:0]      r_rom_address;
  logic [DW-1:0]      r_rsp_data;
  logic [ROM_LAT-1:0] r_pipe_v;
  logic [IW-1:0]      r_pipe_id [ROM_LAT];
  logic               w_found, w_head_v;
  logic [IW-1:0]      w_idx, w_head_id, w_ptr_nxt;
  logic [N_REQ-1:0]   w_elig, w_gnt_oh, w_rsp_oh;
  logic [AW-1:0]      w_addr [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign w_addr[g] = req_addr[g*AW +: AW];
  end
  assign w_elig = req & ~r_pending;
  rr_pick #(.N(N_REQ)) u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_found(w_found),
    .o_idx  (w_idx)
  );
  assign w_gnt_oh  = w_found ? N_REQ'(1) << w_idx : '0;
  assign w_ptr_nxt = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  // the registered grant is stage zero; the head lines up with rom_data
  assign w_head_v  = r_pipe_v[ROM_LAT-1];
  assign w_head_id = r_pipe_id[ROM_LAT-1];
  assign w_rsp_oh  = w_head_v ? N_REQ'(1) << w_head_id : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= '0;
      r_ptr         <= '0;
      r_gnt         <= '0;
      r_gnt_id      <= '0;
      r_rom_address <= '0;
      r_pipe_v      <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
    end else begin
      r_gnt       <= w_gnt_oh;
      r_gnt_id    <= w_idx;
      r_pending   <= (r_pending & ~w_rsp_oh) | w_gnt_oh;
      r_pipe_v    <= ROM_LAT'({r_pipe_v, |r_gnt});
      r_rsp_valid <= w_rsp_oh;
      if (w_head_v) r_rsp_data <= rom_data;
      if (w_found) begin
        r_ptr         <= w_ptr_nxt;
        r_rom_address <= w_addr[w_idx];
      end
    end
  end
  always_ff @(posedge clk) begin
    r_pipe_id[0] <= r_gnt_id;
    for (int i = 1; i < ROM_LAT; i++) r_pipe_id[i] <= r_pipe_id[i-1];
  end
  assign gnt         = r_gnt;
  assign rom_address = r_rom_address;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: two arbiters (ROM latency 1 and 3) against a behavioural round-robin model
module tb_font_rom_arbiter;
  import font_rom_arbiter_pkg::*;
  localparam int N = 16;
  localparam int AW = 10;
  localparam int DW = 32;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    gnt [2];
  logic [N-1:0]    rsp_valid [2];
  logic [AW-1:0]   rom_address [2];
  logic [DW-1:0]   rom_data [2];
  logic [DW-1:0]   rsp_data [2];
  logic [DW-1:0]   rq0, rq1a, rq1b, rq1c;
  logic [AW-1:0]   ra [N];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int g5_cyc = -10;
  logic [N-1:0]  m_pend [2];
  logic [N-1:0]  e_gnt [2];
  logic [N-1:0]  e_rv [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_rd [2];
  int            m_ptr [2];
  int            due [2][N];
  logic [AW-1:0] fa [2][N];

  always #5 clk = ~clk;

  font_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(1)) u0 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt[0]),
    .rom_address(rom_address[0]), .rom_data(rom_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0])
  );
  font_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(3)) u1 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt[1]),
    .rom_address(rom_address[1]), .rom_data(rom_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1])
  );

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return 32'(a) * 32'h9E37_79B1 + 32'h00C0_FFEE;
  endfunction

  // synchronous ROMs of latency 1 and 3
  always @(posedge clk) begin
    rq0  <= romf(rom_address[0]);
    rq1a <= romf(rom_address[1]);
    rq1b <= rq1a;
    rq1c <= rq1b;
  end
  assign rom_data[0] = rq0;
  assign rom_data[1] = rq1c;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one cycle of the reference: responses fall due by cycle number, grants scan from ptr
  task automatic step(input int i);
    int lat, k, start;
    logic [N-1:0] elig;
    lat = (i == 0) ? 1 : 3;
    elig = req & ~m_pend[i];
    if (rst) begin
      m_ptr[i] = 0;
      m_pend[i] = '0;
      e_gnt[i] = '0;
      e_rv[i] = '0;
      e_addr[i] = '0;
      e_rd[i] = '0;
      for (int j = 0; j < N; j++) due[i][j] = -1;
    end else begin
      e_rv[i] = '0;
      e_gnt[i] = '0;
      for (int j = 0; j < N; j++)
        if (due[i][j] == cyc + 1) begin
          e_rv[i][j] = 1'b1;
          e_rd[i] = romf(fa[i][j]);
          m_pend[i][j] = 1'b0;
          due[i][j] = -1;
        end
      start = m_ptr[i];
      for (int s = 0; s < N; s++) begin
        k = (start + s) % N;
        if (e_gnt[i] == '0 && elig[k]) begin
          e_gnt[i][k] = 1'b1;
          e_addr[i] = req_addr[k*AW +: AW];
          m_pend[i][k] = 1'b1;
          due[i][k] = cyc + lat + 2;
          fa[i][k] = req_addr[k*AW +: AW];
          m_ptr[i] = (k + 1) % N;
        end
      end
    end
  endtask

  task automatic drive();
    logic [N-1:0] nr;
    nr = '0;
    rst = (cyc < 4) || (cyc == g5_cyc + 1);
    if (cyc >= 4 && cyc < 14) begin
      nr[3] = 1'b1;
      ra[3] = 10'h12A;
    end else if (cyc >= 20 && cyc < 60) begin
      if (cyc == 20) for (int j = 0; j < N; j++) ra[j] = AW'($urandom);
      nr = '1;
    end else if (cyc == 70) begin
      nr[13] = 1'b1;
    end else if (cyc >= 76 && cyc < 86) begin
      nr[2] = 1'b1;
      nr[15] = 1'b1;
    end else if (cyc >= 93 && cyc < 111) begin
      nr[5] = 1'b1;
    end else if (cyc == 121 || cyc == 122) begin
      nr[0] = 1'b1;
      nr[1] = 1'b1;
    end else if (cyc >= 136) begin
      for (int j = 0; j < N; j++) begin
        nr[j] = req[j] ? ($urandom_range(3) != 0) : ($urandom_range(1) == 1);
        if (!nr[j]) ra[j] = AW'($urandom);
      end
      if ($urandom_range(99) == 0) rst = 1'b1;
    end
    req = nr;
    for (int j = 0; j < N; j++) req_addr[j*AW +: AW] = ra[j];
  endtask

  initial begin
    for (int j = 0; j < N; j++) ra[j] = '0;
    drive();
    step(0);
    step(1);
    for (cyc = 1; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d gnt c%0d", i, cyc), 64'(gnt[i]), 64'(e_gnt[i]));
        check($sformatf("u%0d rom_address c%0d", i, cyc), 64'(rom_address[i]), 64'(e_addr[i]));
        check($sformatf("u%0d rsp_valid c%0d", i, cyc), 64'(rsp_valid[i]), 64'(e_rv[i]));
        check($sformatf("u%0d rsp_data c%0d", i, cyc), 64'(rsp_data[i]), 64'(e_rd[i]));
      end
      if (cyc >= 94 && g5_cyc < 0 && e_gnt[0][5]) g5_cyc = cyc;
      drive();
      step(0);
      step(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
